// File: rtl/output_writeback_ctrl.sv
// rtl/output_writeback_ctrl.sv - splits packed activation words into half-word SRAM write beats
module output_writeback_ctrl #(
  parameter int N_DIM_ARRAY    = 8,
  parameter int ACT_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int MODE_CNN       = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [2:0]                            mode,
  input  logic                                  cfg_start,
  input  logic [ADDR_WIDTH-1:0]                 cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]                 cfg_addr_stride,
  input  logic [CNT_WIDTH-1:0]                  cfg_num_words,
  input  logic                                  in_valid,
  input  logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0] in_word,
  output logic                                  in_ready,
  output logic                                  mem_req,
  output logic [ADDR_WIDTH-1:0]                 mem_addr,
  output logic [N_DIM_ARRAY*ACT_DATA_WIDTH/2-1:0] mem_wdata,
  input  logic                                  mem_gnt,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err_overflow
);

  localparam int WORD_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
  localparam int HALF_W = WORD_W / 2;
  localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(HALF_W / 8);
  localparam logic [2:0] MODE_CNN_ENC = 3'(MODE_CNN);

  typedef enum logic [2:0] {IDLE, WAIT_IN, WR_LO, WR_HI, FINISH} state_t;

  state_t                 state_q;
  logic [2:0]             mode_q;
  logic [ADDR_WIDTH-1:0]  word_addr_q;
  logic [ADDR_WIDTH-1:0]  beat_addr_q;
  logic [ADDR_WIDTH-1:0]  stride_q;
  logic [CNT_WIDTH-1:0]   remaining_q;
  logic [HALF_W-1:0]      holding_hi_q;
  logic                   in_ready_q;
  logic                   mem_req_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [HALF_W-1:0]      mem_wdata_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   is_cnn;
  logic                   word_done;
  logic [ADDR_WIDTH-1:0]  word_addr_d;

  assign is_cnn      = (mode_q == MODE_CNN_ENC);
  assign word_done   = mem_gnt && (((state_q == WR_LO) && !is_cnn) || (state_q == WR_HI));
  assign word_addr_d = word_addr_q + stride_q;

  // The low half of an accepted word goes straight into the beat data register;
  // only the upper half needs to be held for the second CNN beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      mode_q       <= '0;
      word_addr_q  <= '0;
      beat_addr_q  <= '0;
      stride_q     <= '0;
      remaining_q  <= '0;
      holding_hi_q <= '0;
      in_ready_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) err_q <= 1'b1;
          if (cfg_start) begin
            mode_q      <= mode;
            word_addr_q <= cfg_base_addr;
            beat_addr_q <= cfg_base_addr;
            stride_q    <= cfg_addr_stride;
            remaining_q <= cfg_num_words;
            busy_q      <= 1'b1;
            err_q       <= in_valid;
            if (cfg_num_words == '0) begin
              state_q <= FINISH;
            end else begin
              state_q    <= WAIT_IN;
              in_ready_q <= 1'b1;
            end
          end
        end
        WAIT_IN: begin
          if (in_valid && in_ready_q) begin
            holding_hi_q <= in_word[WORD_W-1:HALF_W];
            mem_wdata_q  <= in_word[HALF_W-1:0];
            mem_addr_q   <= beat_addr_q;
            mem_req_q    <= 1'b1;
            in_ready_q   <= 1'b0;
            state_q      <= WR_LO;
          end
        end
        WR_LO: begin
          if (mem_gnt && is_cnn) begin
            beat_addr_q <= beat_addr_q + BEAT_BYTES;
            mem_addr_q  <= beat_addr_q + BEAT_BYTES;
            mem_wdata_q <= holding_hi_q;
            state_q     <= WR_HI;
          end
        end
        WR_HI: ;
        FINISH: begin
          if (in_valid) err_q <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      if (word_done) begin
        mem_req_q   <= 1'b0;
        remaining_q <= (remaining_q != '0) ? remaining_q - CNT_WIDTH'(1) : '0;
        word_addr_q <= word_addr_d;
        beat_addr_q <= word_addr_d;
        if (remaining_q <= CNT_WIDTH'(1)) begin
          state_q <= FINISH;
        end else begin
          state_q    <= WAIT_IN;
          in_ready_q <= 1'b1;
        end
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_overflow = err_q;

endmodule
